// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 Hz timing generator.
// Divides the board clock down to a pixel enable and runs free horizontal and vertical
// counters. Sync, bright and strobes are decoded combinationally from the registered state.
// Optional feature: define VGA_FRAME_CNT_EN to get a registered 8-bit frame counter;
// otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned H_TOTAL      = 800,
   parameter int unsigned H_SYNC       = 96,
   parameter int unsigned H_DISP_START = 144,
   parameter int unsigned H_DISP_END   = 784,
   parameter int unsigned V_TOTAL      = 525,
   parameter int unsigned V_SYNC       = 2,
   parameter int unsigned V_DISP_START = 35,
   parameter int unsigned V_DISP_END   = 515
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_tick,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       hSync,
   output logic       vSync,
   output logic       bright,
   output logic       line_tick,
   output logic       frame_tick,
   output logic [7:0] frame_cnt
);

   localparam logic [3:0] DivLast = 4'(CLK_DIV - 1);
   localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
   localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);

   logic [3:0] div_cnt_q, div_cnt_d;
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       h_last, v_last;

   // Compare with an extra bit so an exclusive bound of 1024 still works.
   logic [10:0] h_ext, v_ext;

   // Pixel enable and strobe decode; pix_tick is masked during reset for CLK_DIV=1.
   always_comb begin
      pix_tick   = (div_cnt_q == DivLast) && !rst;
      h_last     = (h_cnt_q == HLast);
      v_last     = (v_cnt_q == VLast);
      line_tick  = pix_tick && h_last;
      frame_tick = line_tick && v_last;
   end

   // Next-state for divider and pixel/line counters.
   always_comb begin
      div_cnt_d = div_cnt_q + 4'd1;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      if (pix_tick) begin
         div_cnt_d = 4'd0;
         if (h_last) begin
            h_cnt_d = 10'd0;
            v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end
   end

   // Timing state registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= 4'd0;
         h_cnt_q   <= 10'd0;
         v_cnt_q   <= 10'd0;
      end else begin
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
      end
   end

   // Sync and visible-area decode straight from the counters.
   always_comb begin
      h_ext  = {1'b0, h_cnt_q};
      v_ext  = {1'b0, v_cnt_q};
      hCount = h_cnt_q;
      vCount = v_cnt_q;
      hSync  = !(h_ext < 11'(H_SYNC));
      vSync  = !(v_ext < 11'(V_SYNC));
      bright = (h_ext >= 11'(H_DISP_START)) && (h_ext < 11'(H_DISP_END)) &&
               (v_ext >= 11'(V_DISP_START)) && (v_ext < 11'(V_DISP_END));
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;

   // Frame counter steps on each frame strobe and wraps naturally.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_tick) frame_cnt_d = frame_cnt_q + 8'd1;
   end

   // Frame counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_cnt_q <= 8'd0;
      else     frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so whole frames fit in a
// short run. Expected outputs come from an arithmetic model indexed by clock count since
// reset release, pushed into a scoreboard on each edge and popped at the following negedge.
module tb_vga_timing_gen;

   localparam int CD  = 4;
   localparam int HT  = 40;
   localparam int HS  = 6;
   localparam int HDS = 9;
   localparam int HDE = 37;
   localparam int VT  = 12;
   localparam int VS  = 2;
   localparam int VDS = 3;
   localparam int VDE = 10;
   localparam int FRAME_CLKS = HT * VT * CD;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pix_tick, hSync, vSync, bright, line_tick, frame_tick;
   logic [9:0] hCount, vCount;
   logic [7:0] frame_cnt;

   int checks = 0;
   int errors = 0;
   int n = 0;
   logic [34:0] sb[$];

   vga_timing_gen #(
      .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_DISP_START(HDS), .H_DISP_END(HDE),
      .V_TOTAL(VT), .V_SYNC(VS), .V_DISP_START(VDS), .V_DISP_END(VDE)
   ) dut (
      .clk(clk), .rst(rst), .pix_tick(pix_tick), .hCount(hCount), .vCount(vCount),
      .hSync(hSync), .vSync(vSync), .bright(bright), .line_tick(line_tick),
      .frame_tick(frame_tick), .frame_cnt(frame_cnt)
   );

   initial forever #5 clk = ~clk;

   // Packing: {pix, line, frame, hs, vs, br, h[9:0], v[9:0], fc[7:0]}
   function automatic logic [34:0] model(input int k);
      int p, d, h, v, f;
      logic pix, ln, fr, hs, vs, br;
      logic [7:0] fc;
      p  = k / CD;
      d  = k % CD;
      h  = p % HT;
      v  = (p / HT) % VT;
      f  = p / (HT * VT);
      pix = (d == CD - 1);
      ln  = pix && (h == HT - 1);
      fr  = ln && (v == VT - 1);
      hs  = !(h < HS);
      vs  = !(v < VS);
      br  = (h >= HDS) && (h < HDE) && (v >= VDS) && (v < VDE);
`ifdef VGA_FRAME_CNT_EN
      fc = 8'(f);
`else
      fc = 8'd0;
`endif
      return {pix, ln, fr, hs, vs, br, 10'(h), 10'(v), fc};
   endfunction

   function automatic logic [34:0] observe();
      return {pix_tick, line_tick, frame_tick, hSync, vSync, bright, hCount, vCount, frame_cnt};
   endfunction

   // One clock of stimulus: push the expectation for the new state, then move to sampling.
   task automatic step();
      @(posedge clk);
      n++;
      sb.push_back(model(n));
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [34:0] obs;
      #3 rst = 1'b1;
      #1;
      obs = observe();
      checks++;
      if (obs !== 35'd0) begin
         errors++;
         $display("FAIL reset_async got=%h exp=%h", obs, 35'd0);
      end
      repeat (3) @(negedge clk);
      obs = observe();
      checks++;
      if (obs !== 35'd0) begin
         errors++;
         $display("FAIL reset_held got=%h exp=%h", obs, 35'd0);
      end
      rst = 1'b0;
      n = 0;
      #1;
      obs = observe();
      checks++;
      if (obs !== model(0)) begin
         errors++;
         $display("FAIL reset_release got=%h exp=%h", obs, model(0));
      end
   endtask

   // First line after release: tick cadence, first step, one line strobe, wrap to line 1.
   task automatic test_first_line(input string tag);
      logic [34:0] exp, obs;
      int lines = 0;
      for (int i = 0; i < HT * CD + CD; i++) begin
         step();
         exp = sb.pop_front();
         obs = observe();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s_state n=%0d got=%h exp=%h", tag, n, obs, exp);
         end
         if (line_tick) lines++;
         if (n == CD) begin
            checks++;
            if (hCount !== 10'd1 || vCount !== 10'd0) begin
               errors++;
               $display("FAIL %s_first_step h=%0d v=%0d exp h=1 v=0", tag, hCount, vCount);
            end
         end
      end
      checks++;
      if (lines != 1) begin
         errors++;
         $display("FAIL %s_line_ticks got=%0d exp=1", tag, lines);
      end
      checks++;
      if (hCount !== 10'd1 || vCount !== 10'd1) begin
         errors++;
         $display("FAIL %s_next_line h=%0d v=%0d exp h=1 v=1", tag, hCount, vCount);
      end
   endtask

   // Remainder of frame 0 plus the first pixels of frame 1.
   task automatic test_full_frame();
      logic [34:0] exp, obs;
      int bright_px = 0;
      int frames = 0;
      int frame_n = -1;
      int vs_low_max = -1;
      int corner_h[7] = '{HDS, HDE - 1, HDE - 1, HDS - 1, HDE, HDS, HDS};
      int corner_v[7] = '{VDS, VDS, VDE - 1, VDS, VDS, VDS - 1, VDE};
      logic corner_b[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      // Account for the bright pixels of line 0 already passed (none: line 0 is blank).
      while (n < FRAME_CLKS + CD) begin
         step();
         exp = sb.pop_front();
         obs = observe();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL frame_state n=%0d got=%h exp=%h", n, obs, exp);
         end
         if (n < FRAME_CLKS && pix_tick && bright) bright_px++;
         if (frame_tick) begin
            frames++;
            frame_n = n;
         end
         if (!vSync && n < FRAME_CLKS && int'(vCount) > vs_low_max) vs_low_max = int'(vCount);
         for (int c = 0; c < 7; c++) begin
            if (n == (corner_v[c] * HT + corner_h[c]) * CD) begin
               checks++;
               if (bright !== corner_b[c]) begin
                  errors++;
                  $display("FAIL bright_corner (%0d,%0d) got=%b exp=%b",
                           corner_h[c], corner_v[c], bright, corner_b[c]);
               end
            end
         end
      end
      checks++;
      if (bright_px != (HDE - HDS) * (VDE - VDS)) begin
         errors++;
         $display("FAIL bright_count got=%0d exp=%0d", bright_px, (HDE - HDS) * (VDE - VDS));
      end
      checks++;
      if (frames != 1 || frame_n != FRAME_CLKS - 1) begin
         errors++;
         $display("FAIL frame_tick count=%0d at n=%0d exp count=1 at n=%0d",
                  frames, frame_n, FRAME_CLKS - 1);
      end
      checks++;
      if (vs_low_max != VS - 1) begin
         errors++;
         $display("FAIL vsync_low_last_line got=%0d exp=%0d", vs_low_max, VS - 1);
      end
   endtask

   // Two more frames to exercise frame_cnt stepping (or staying zero).
   task automatic test_frame_cnt();
      logic [34:0] exp, obs;
      logic [7:0]  fc_exp;
      while (n < 3 * FRAME_CLKS + 2) begin
         step();
         exp = sb.pop_front();
         obs = observe();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL fcnt_state n=%0d got=%h exp=%h", n, obs, exp);
         end
      end
`ifdef VGA_FRAME_CNT_EN
      fc_exp = 8'd3;
`else
      fc_exp = 8'd0;
`endif
      checks++;
      if (frame_cnt !== fc_exp) begin
         errors++;
         $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, fc_exp);
      end
   endtask

   // Reset asserted between edges mid-frame, then the first line must repeat.
   task automatic test_async_reset();
      logic [34:0] exp, obs;
      int target;
      target = 3 * FRAME_CLKS + (6 * HT + 25) * CD + 1;
      while (n < target) begin
         step();
         exp = sb.pop_front();
         obs = observe();
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL pre_rst_state n=%0d got=%h exp=%h", n, obs, exp);
         end
      end
      #2 rst = 1'b1;
      #1;
      obs = observe();
      checks++;
      if (obs !== 35'd0) begin
         errors++;
         $display("FAIL midframe_reset got=%h exp=%h", obs, 35'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      #1;
      obs = observe();
      checks++;
      if (obs !== model(0)) begin
         errors++;
         $display("FAIL midframe_release got=%h exp=%h", obs, model(0));
      end
      test_first_line("rerun");
   endtask

   initial begin
      test_reset();
      test_first_line("line");
      test_full_frame();
      test_frame_cnt();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
